// File: rtl/obi_master_pkg.sv
// Shared types and helpers for the OBI data-bus initiator.
//   obi_cmd_t       : one bus command (address, write enable, byte enables, write data)
//   obi_mst_state_e : address-phase FSM states
//   OBI_BE_WIDTH    : byte-enable width for the default 32-bit data bus
//   obi_be_width()  : byte-enable width for an arbitrary data width
package obi_master_pkg;

  localparam int OBI_ADDR_WIDTH = 32;
  localparam int OBI_DATA_WIDTH = 32;
  localparam int OBI_BE_WIDTH   = OBI_DATA_WIDTH / 8;

  typedef struct packed {
    logic [OBI_ADDR_WIDTH-1:0] addr;
    logic                      we;
    logic [OBI_BE_WIDTH-1:0]   be;
    logic [OBI_DATA_WIDTH-1:0] wdata;
  } obi_cmd_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } obi_mst_state_e;

  function automatic int obi_be_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/obi_sync_fifo.sv
// Generic synchronous FIFO with first-word fall-through read port.
//   i_clk, i_rst : clock, asynchronous active-high reset (clears pointers/count)
//   i_push/i_wdata : write side; a push while full is dropped
//   i_pop          : read side; a pop while empty is ignored
//   o_rdata        : current head entry (valid while !o_empty)
//   o_full/o_empty : occupancy flags
// DEPTH need not be a power of two; the pointers wrap explicitly.
module obi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= ptr_inc(r_wptr);
      if (w_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset: entries are only read after being written.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/obi_data_master.sv
// OBI data-bus initiator: buffers read/write commands and issues them as
// pipelined, in-order OBI transactions, returning one response per command.
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   cmd_*              : valid/ready command port (addr, we, be, wdata)
//   rsp_*              : registered one-cycle response (we echo, read data)
//   data_*             : OBI req/gnt/rvalid master interface
//   busy_o             : work queued, requested or outstanding
//   protocol_err_o     : sticky flag for an rvalid with nothing outstanding
module obi_data_master
  import obi_master_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int CMD_FIFO_DEPTH  = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
  input  logic                    cmd_we_i,
  input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
  output logic                    rsp_valid_o,
  output logic                    rsp_we_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    data_req_o,
  input  logic                    data_gnt_i,
  output logic [ADDR_WIDTH-1:0]   data_addr_o,
  output logic                    data_we_o,
  output logic [DATA_WIDTH/8-1:0] data_be_o,
  output logic [DATA_WIDTH-1:0]   data_wdata_o,
  input  logic                    data_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   data_rdata_i,
  output logic                    busy_o,
  output logic                    protocol_err_o
);

  localparam int BE_W  = obi_be_width(DATA_WIDTH);
  localparam int CMD_W = ADDR_WIDTH + 1 + BE_W + DATA_WIDTH;
  localparam int OW    = $clog2(MAX_OUTSTANDING + 1);

  obi_mst_state_e    r_state, w_state_nxt;
  logic [OW-1:0]     r_outst;
  logic [CMD_W-1:0]  w_cmd_in, w_fifo_rdata, w_head;
  logic              w_fifo_full, w_fifo_empty, w_fifo_push, w_fifo_pop;
  logic              w_accept, w_avail, w_take, w_req, w_grant;
  logic              w_credit, w_room_b2b;
  logic              w_we_head, w_we_full, w_we_empty;
  logic              w_spurious, w_rsp_take;
  logic              r_rsp_valid, r_rsp_we, r_err;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  // Command intake
  assign w_cmd_in    = {cmd_addr_i, cmd_we_i, cmd_be_i, cmd_wdata_i};
  assign cmd_ready_o = ~w_fifo_full;
  assign w_accept    = cmd_valid_i & cmd_ready_o;

  // When the FIFO is empty the incoming command is the head, so an accepted
  // command can be loaded straight into the address registers and appear on
  // the bus the following cycle.
  assign w_avail     = ~w_fifo_empty | w_accept;
  assign w_head      = w_fifo_empty ? w_cmd_in : w_fifo_rdata;
  assign w_fifo_pop  = w_take & ~w_fifo_empty;
  assign w_fifo_push = w_accept & ~(w_take & w_fifo_empty);

  obi_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_FIFO_DEPTH)
  ) u_cmd_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_fifo_push),
    .i_wdata (w_cmd_in),
    .i_pop   (w_fifo_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Address phase FSM. Credit looks only at the registered count, so an
  // rvalid arriving this cycle does not free a slot until next cycle.
  assign w_credit   = (int'(r_outst) < MAX_OUTSTANDING);
  assign w_room_b2b = ((int'(r_outst) + 1) < MAX_OUTSTANDING);
  assign w_grant    = w_req & data_gnt_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_avail && w_credit) w_state_nxt = REQ;
      REQ:     if (data_gnt_i) w_state_nxt = (w_avail && w_room_b2b) ? REQ : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_req  = 1'b0;
    w_take = 1'b0;
    case (r_state)
      IDLE: w_take = w_avail & w_credit;
      REQ: begin
        w_req  = 1'b1;
        w_take = data_gnt_i & w_avail & w_room_b2b;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_addr_o  <= '0;
      data_we_o    <= 1'b0;
      data_be_o    <= '0;
      data_wdata_o <= '0;
    end else if (w_take) begin
      {data_addr_o, data_we_o, data_be_o, data_wdata_o} <= w_head;
    end
  end

  assign data_req_o = w_req;

  // Outstanding tracking. The we-FIFO occupancy mirrors r_outst, so its
  // empty flag identifies an rvalid with nothing outstanding.
  assign w_spurious = data_rvalid_i & w_we_empty & ~w_grant;
  assign w_rsp_take = data_rvalid_i & ~w_spurious;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_outst <= '0;
    end else begin
      case ({w_grant, w_rsp_take})
        2'b10:   r_outst <= r_outst + 1'b1;
        2'b01:   r_outst <= r_outst - 1'b1;
        default: r_outst <= r_outst;
      endcase
    end
  end

  obi_sync_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUTSTANDING)
  ) u_we_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_grant),
    .i_wdata (data_we_o),
    .i_pop   (w_rsp_take),
    .o_rdata (w_we_head),
    .o_full  (w_we_full),
    .o_empty (w_we_empty)
  );

  // Response stage; we and rdata read as zero outside a response pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_rdata <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= w_rsp_take;
      r_rsp_we    <= w_rsp_take & w_we_head;
      r_rsp_rdata <= (w_rsp_take && !w_we_head) ? data_rdata_i : '0;
      r_err       <= r_err | w_spurious;
    end
  end

  assign rsp_valid_o    = r_rsp_valid;
  assign rsp_we_o       = r_rsp_we;
  assign rsp_rdata_o    = r_rsp_rdata;
  assign protocol_err_o = r_err;
  // A full we-FIFO means no credit; this is the same condition as !w_credit.
  assign busy_o         = ~w_fifo_empty | w_req | (r_outst != '0) | w_we_full;

endmodule

// File: tb/tb_obi_data_master.sv
module tb_obi_data_master;
  import obi_master_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = OBI_BE_WIDTH;
  localparam int DEPTH = 4;
  localparam int MAXO  = 2;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          cmd_valid_i, cmd_ready_o, cmd_we_i;
  logic [AW-1:0] cmd_addr_i;
  logic [BW-1:0] cmd_be_i;
  logic [DW-1:0] cmd_wdata_i;
  logic          rsp_valid_o, rsp_we_o;
  logic [DW-1:0] rsp_rdata_o;
  logic          data_req_o, data_gnt_i, data_we_o, data_rvalid_i;
  logic [AW-1:0] data_addr_o;
  logic [BW-1:0] data_be_o;
  logic [DW-1:0] data_wdata_o, data_rdata_i;
  logic          busy_o, protocol_err_o;

  always #5 clk = ~clk;

  obi_data_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_addr_i(cmd_addr_i),
    .cmd_we_i(cmd_we_i), .cmd_be_i(cmd_be_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_we_o(rsp_we_o), .rsp_rdata_o(rsp_rdata_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i),
    .busy_o(busy_o), .protocol_err_o(protocol_err_o)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Transaction-level model: commands waiting, command on the bus,
  // granted-but-unanswered transactions, expected response and error flag.
  obi_cmd_t    m_fifo[$];
  obi_cmd_t    m_head;
  bit          m_req, m_err, m_rv, m_rwe;
  bit          m_out[$];
  logic [31:0] m_rdata;

  task automatic model_reset();
    m_fifo.delete(); m_out.delete();
    m_head = '0; m_req = 0; m_err = 0; m_rv = 0; m_rwe = 0; m_rdata = '0;
  endtask

  task automatic model_update();
    obi_cmd_t inc;
    bit acc, grant, used;
    int n;
    if (rst_i) begin model_reset(); return; end
    inc.addr = cmd_addr_i; inc.we = cmd_we_i; inc.be = cmd_be_i; inc.wdata = cmd_wdata_i;
    acc   = cmd_valid_i && (m_fifo.size() < DEPTH);
    grant = m_req && data_gnt_i;
    n     = m_out.size();
    used  = 0;
    m_rv = 0; m_rwe = 0; m_rdata = '0;
    if (data_rvalid_i) begin
      if (n > 0) begin
        m_rv = 1; m_rwe = m_out.pop_front();
        m_rdata = m_rwe ? 32'h0 : data_rdata_i;
      end else if (!grant) m_err = 1;
    end
    if (grant) m_out.push_back(m_head.we);
    if (m_req && !grant) begin
      m_req = 1;
    end else if ((!m_req && n < MAXO) || (grant && n + 1 < MAXO)) begin
      if (m_fifo.size() > 0) begin m_head = m_fifo.pop_front(); m_req = 1; end
      else if (acc) begin m_head = inc; m_req = 1; used = 1; end
      else m_req = 0;
    end else begin
      m_req = 0;
    end
    if (acc && !used) m_fifo.push_back(inc);
  endtask

  // Responder and stimulus state
  int          cyc = 0, gnt_delay = 0, rv_delay = 2, req_age = 0;
  int          due_q[$];
  logic [31:0] rd_q[$];
  bit          force_rv = 0, last_acc = 0, chk_en = 0;
  int          req_cycles = 0, gnt_cnt = 0;
  logic [32:0] rsp_log[$];

  task automatic tick();
    bit g;
    g = data_req_o && data_gnt_i;
    last_acc = cmd_valid_i && cmd_ready_o;
    @(posedge clk);
    model_update();
    cyc++;
    if (g) begin due_q.push_back(cyc + rv_delay - 1); req_age = 0; end
    #1;
    if (data_req_o) begin data_gnt_i = (req_age >= gnt_delay); req_age++; end
    else data_gnt_i = 1'b0;
    if (force_rv) begin
      data_rvalid_i = 1'b1; data_rdata_i = 32'hBAD; force_rv = 0;
    end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
      void'(due_q.pop_front());
      data_rvalid_i = 1'b1;
      data_rdata_i  = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
    end else begin
      data_rvalid_i = 1'b0; data_rdata_i = '0;
    end
  endtask

  task automatic send(input logic [31:0] a, input bit we, input logic [3:0] be, input logic [31:0] wd);
    bit ok;
    ok = 0;
    cmd_valid_i = 1'b1; cmd_addr_i = a; cmd_we_i = we; cmd_be_i = be; cmd_wdata_i = wd;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (last_acc) begin ok = 1; break; end
    end
    cmd_valid_i = 1'b0;
    if (!ok) check("send_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      if (!busy_o && due_q.size() == 0 && !data_rvalid_i) begin ok = 1; break; end
      tick();
    end
    if (!ok) check("idle_timeout", 1, 0);
    tick(); tick();
  endtask

  task automatic clear_stats();
    req_cycles = 0; gnt_cnt = 0; rsp_log.delete();
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (chk_en && !rst_i) begin
      check("req", data_req_o, m_req);
      if (m_req) begin
        check("addr", data_addr_o, m_head.addr);
        check("we", data_we_o, m_head.we);
        check("be", data_be_o, m_head.be);
        check("wdata", data_wdata_o, m_head.wdata);
      end
      check("cmd_ready", cmd_ready_o, m_fifo.size() < DEPTH);
      check("busy", busy_o, (m_fifo.size() != 0) || m_req || (m_out.size() != 0));
      check("rsp_valid", rsp_valid_o, m_rv);
      check("rsp_we", rsp_we_o, m_rwe);
      check("rsp_rdata", rsp_rdata_o, m_rdata);
      check("perr", protocol_err_o, m_err);
      if (data_req_o) req_cycles++;
      if (data_req_o && data_gnt_i) gnt_cnt++;
      if (rsp_valid_o) rsp_log.push_back({rsp_we_o, rsp_rdata_o});
    end
  end

  initial begin
    bit seen;
    rst_i = 1'b1; cmd_valid_i = 0; cmd_addr_i = '0; cmd_we_i = 0; cmd_be_i = '0;
    cmd_wdata_i = '0; data_gnt_i = 0; data_rvalid_i = 0; data_rdata_i = '0;
    model_reset();
    repeat (2) tick();
    check("rst_cmd_ready", cmd_ready_o, 1);
    check("rst_req", data_req_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_perr", protocol_err_o, 0);
    check("rst_addr", data_addr_o, 0);
    rst_i = 1'b0; chk_en = 1;
    tick();

    // Single write, immediate grant, rvalid two cycles later
    clear_stats(); gnt_delay = 0; rv_delay = 2;
    send(32'h100, 1, 4'hF, 32'hDEADBEEF);
    check("t1_latency", data_req_o, 1);
    wait_idle();
    check("t1_req_cycles", req_cycles, 1);
    check("t1_rsp_n", rsp_log.size(), 1);
    if (rsp_log.size() > 0) check("t1_rsp", rsp_log[0], {1'b1, 32'h0});
    check("t1_busy", busy_o, 0);

    // Read with grant held off three cycles
    clear_stats(); gnt_delay = 3; rv_delay = 1; rd_q = '{32'h12345678};
    send(32'h200, 0, 4'hF, 32'h0);
    wait_idle();
    check("t2_req_cycles", req_cycles, 4);
    check("t2_rsp_n", rsp_log.size(), 1);
    if (rsp_log.size() > 0) check("t2_rsp", rsp_log[0], {1'b0, 32'h12345678});

    // Outstanding limit: four reads, late rvalids
    clear_stats(); gnt_delay = 0; rv_delay = 6;
    rd_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    for (int i = 0; i < 4; i++) send(32'h300 + 4 * i, 0, 4'hF, 32'h0);
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      if (rsp_log.size() > 0) begin seen = 1; break; end
      tick();
    end
    check("t3_first_rsp_seen", seen, 1);
    check("t3_grants_before_rsp", gnt_cnt, 2);
    wait_idle();
    check("t3_rsp_n", rsp_log.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < rsp_log.size()) check("t3_rsp_order", rsp_log[i], {1'b0, 32'hA0 + 32'(i)});

    // Backpressure: grant withheld, one command on the bus and four queued
    clear_stats(); gnt_delay = 1000; rv_delay = 2;
    rd_q = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4};
    for (int i = 0; i < 4; i++) send(32'h500 + 4 * i, 0, 4'h3, 32'h0);
    check("t4_ready_before_full", cmd_ready_o, 1);
    send(32'h510, 0, 4'h3, 32'h0);
    check("t4_ready_full", cmd_ready_o, 0);
    check("t4_no_grant", gnt_cnt, 0);
    gnt_delay = 0;
    wait_idle();
    check("t4_rsp_n", rsp_log.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < rsp_log.size()) check("t4_rsp_order", rsp_log[i], {1'b0, 32'hB0 + 32'(i)});

    // Grant of one transaction together with rvalid of the previous one
    clear_stats(); gnt_delay = 0; rv_delay = 1;
    rd_q = '{32'hC0, 32'hC1, 32'hC2};
    for (int i = 0; i < 3; i++) send(32'h600 + 4 * i, 0, 4'hF, 32'h0);
    wait_idle();
    check("t5_grants", gnt_cnt, 3);
    check("t5_req_cycles", req_cycles, 3);
    check("t5_rsp_n", rsp_log.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < rsp_log.size()) check("t5_rsp_order", rsp_log[i], {1'b0, 32'hC0 + 32'(i)});

    // Reset while a request is pending and one transaction is outstanding
    clear_stats(); gnt_delay = 3; rv_delay = 20;
    send(32'h400, 1, 4'hF, 32'h55AA55AA);
    send(32'h404, 0, 4'hF, 32'h0);
    for (int k = 0; k < 30 && gnt_cnt < 1; k++) tick();
    tick();
    check("t6_req_before_rst", data_req_o, 1);
    #2 rst_i = 1'b1;
    #1;
    model_reset(); due_q.delete(); rd_q.delete(); req_age = 0;
    data_gnt_i = 0; data_rvalid_i = 0;
    check("t6_req_dropped", data_req_o, 0);
    check("t6_busy", busy_o, 0);
    check("t6_cmd_ready", cmd_ready_o, 1);
    check("t6_rsp_valid", rsp_valid_o, 0);
    check("t6_addr", data_addr_o, 0);
    tick(); tick();
    rst_i = 1'b0;
    tick();
    check("t6_perr_clear", protocol_err_o, 0);
    force_rv = 1;
    tick();
    tick();
    check("t6_perr_set", protocol_err_o, 1);
    check("t6_no_rsp", rsp_valid_o, 0);
    repeat (3) tick();
    check("t6_perr_sticky", protocol_err_o, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
